// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch/realign stage.
package fetch_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned WADDR_W = 30;
    localparam int unsigned HALF_W  = 16;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        RESET,
        RUN,
        REFILL
    } fetch_state_e;

    // Upper halfword of a fetched word, parked until the PC reaches it
    typedef struct packed {
        logic               valid;
        logic [HALF_W-1:0]  half;
        logic [WADDR_W-1:0] tag;
    } half_buf_t;

    // RVC encodings never have both low opcode bits set
    function automatic logic is_compressed(input logic [HALF_W-1:0] h);
        return h[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_align.sv
// Combinational realigner: picks the instruction at the PC from the carry
// buffer and/or the fetched word, and computes the next buffer contents.
module fetch_align
    import fetch_pkg::*;
(
    input  logic [WADDR_W-1:0] word_pc,
    input  logic               odd_half,
    input  half_buf_t          hbuf_q,
    input  logic [XLEN-1:0]    word,
    output logic               ren,
    output logic [WADDR_W-1:0] addr,
    output logic               avail,
    output logic [XLEN-1:0]    instr,
    output logic               is_long,
    output half_buf_t          hbuf_nxt
);

    logic hit;

    assign hit = hbuf_q.valid && (hbuf_q.tag == word_pc);

    // Select instruction source and next buffer from PC alignment and buffer match
    always_comb begin
        ren      = 1'b1;
        addr     = word_pc;
        avail    = 1'b1;
        instr    = word;
        is_long  = 1'b1;
        hbuf_nxt = {1'b1, word[31:16], word_pc};
        if (!odd_half) begin
            if (is_compressed(word[15:0])) begin
                instr   = {16'h0000, word[15:0]};
                is_long = 1'b0;
            end else begin
                hbuf_nxt.valid = 1'b0;
            end
        end else if (hit) begin
            if (is_compressed(hbuf_q.half)) begin
                ren            = 1'b0;
                instr          = {16'h0000, hbuf_q.half};
                is_long        = 1'b0;
                hbuf_nxt.valid = 1'b0;
            end else begin
                addr         = word_pc + WADDR_W'(1);
                instr        = {word[15:0], hbuf_q.half};
                hbuf_nxt.tag = word_pc + WADDR_W'(1);
            end
        end else begin
            // Upper half of the current word is not buffered: refill it first
            avail = 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_align.sv
// Instruction fetch for RV32IC: PC register, I-cache requests, halfword
// realignment and branch-prediction / redirect steering.
module if_fetch_align
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               Stall_i,
    input  logic               redirect_i,
    input  logic [XLEN-1:0]    redirect_pc_i,
    output logic [XLEN-1:0]    bp_pc_o,
    input  logic               bp_taken_i,
    input  logic [XLEN-1:0]    bp_target_i,
    output logic               ICACHE_ren_o,
    output logic [WADDR_W-1:0] ICACHE_addr_o,
    input  logic [XLEN-1:0]    ICACHE_rdata_i,
    input  logic               ICACHE_stall_i,
    output logic               valid_o,
    output logic [XLEN-1:0]    instr_o,
    output logic [XLEN-1:0]    pc_o,
    output logic [XLEN-1:0]    pc_plus_o,
    output logic               BP_hit_o
);

    fetch_state_e       state_q;
    logic [XLEN-1:0]    pc_q;
    half_buf_t          hbuf_q;

    logic               al_ren;
    logic [WADDR_W-1:0] al_addr;
    logic               al_avail;
    logic [XLEN-1:0]    al_instr;
    logic               al_long;
    half_buf_t          al_hbuf_nxt;

    fetch_align u_align (
        .word_pc  (pc_q[31:2]),
        .odd_half (pc_q[1]),
        .hbuf_q   (hbuf_q),
        .word     (ICACHE_rdata_i),
        .ren      (al_ren),
        .addr     (al_addr),
        .avail    (al_avail),
        .instr    (al_instr),
        .is_long  (al_long),
        .hbuf_nxt (al_hbuf_nxt)
    );

    // Cache request and IF/ID-facing outputs, combinational from state and cache data
    always_comb begin
        valid_o       = 1'b0;
        instr_o       = NOP;
        pc_o          = pc_q;
        pc_plus_o     = pc_q;
        BP_hit_o      = 1'b0;
        bp_pc_o       = pc_q;
        ICACHE_ren_o  = 1'b0;
        ICACHE_addr_o = '0;
        if (rst) begin
            pc_o      = RESET_PC;
            pc_plus_o = RESET_PC;
            bp_pc_o   = RESET_PC;
        end else begin
            case (state_q)
                RUN: begin
                    ICACHE_ren_o  = al_ren;
                    ICACHE_addr_o = al_addr;
                    valid_o       = al_avail && !redirect_i && !ICACHE_stall_i;
                end
                REFILL: begin
                    ICACHE_ren_o  = 1'b1;
                    ICACHE_addr_o = pc_q[31:2];
                end
                default: ;
            endcase
            if (valid_o) begin
                instr_o   = al_instr;
                pc_plus_o = pc_q + (al_long ? XLEN'(4) : XLEN'(2));
                BP_hit_o  = bp_taken_i;
            end
        end
    end

    // FSM, PC and carry buffer; redirect beats cache stall beats pipeline stall
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RESET;
            pc_q         <= RESET_PC;
            hbuf_q.valid <= 1'b0;
        end else if (redirect_i) begin
            state_q      <= RUN;
            pc_q         <= redirect_pc_i & 32'hFFFF_FFFE;
            hbuf_q.valid <= 1'b0;
        end else if (!ICACHE_stall_i && !Stall_i) begin
            case (state_q)
                RESET: state_q <= RUN;
                RUN: begin
                    if (valid_o) begin
                        hbuf_q <= al_hbuf_nxt;
                        if (bp_taken_i) begin
                            pc_q         <= bp_target_i & 32'hFFFF_FFFE;
                            hbuf_q.valid <= 1'b0;
                        end else begin
                            pc_q <= pc_plus_o;
                        end
                    end else begin
                        state_q <= REFILL;
                    end
                end
                REFILL: begin
                    hbuf_q  <= al_hbuf_nxt;
                    state_q <= RUN;
                end
                default: state_q <= RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_align.sv
// Bench for if_fetch_align: directed scenarios followed by randomized traffic
// checked against an instruction-stream model of memory.
module tb_if_fetch_align;

    localparam logic [31:0] NOP_I = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        Stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] bp_pc_o;
    logic        bp_taken_i;
    logic [31:0] bp_target_i;
    logic        ICACHE_ren_o;
    logic [29:0] ICACHE_addr_o;
    logic [31:0] ICACHE_rdata_i;
    logic        ICACHE_stall_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus_o;
    logic        BP_hit_o;

    logic [31:0] mem [128];

    int n_cmp;
    int n_bad;

    if_fetch_align dut (
        .clk            (clk),
        .rst            (rst),
        .Stall_i        (Stall_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .bp_pc_o        (bp_pc_o),
        .bp_taken_i     (bp_taken_i),
        .bp_target_i    (bp_target_i),
        .ICACHE_ren_o   (ICACHE_ren_o),
        .ICACHE_addr_o  (ICACHE_addr_o),
        .ICACHE_rdata_i (ICACHE_rdata_i),
        .ICACHE_stall_i (ICACHE_stall_i),
        .valid_o        (valid_o),
        .instr_o        (instr_o),
        .pc_o           (pc_o),
        .pc_plus_o      (pc_plus_o),
        .BP_hit_o       (BP_hit_o)
    );

    // Cache data is only meaningful on an unstalled request; poison otherwise
    assign ICACHE_rdata_i = (ICACHE_ren_o && !ICACHE_stall_i) ? mem[ICACHE_addr_o[6:0]]
                                                               : 32'hDEAD_BEEF;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_issue(input string tag, input logic [31:0] pc,
                             input logic [31:0] ins, input logic [31:0] plus);
        chk({tag, ".valid"}, 32'(valid_o), 32'd1);
        chk({tag, ".pc"},    pc_o,         pc);
        chk({tag, ".instr"}, instr_o,      ins);
        chk({tag, ".plus"},  pc_plus_o,    plus);
    endtask

    task automatic chk_bubble(input string tag, input logic [31:0] pc);
        chk({tag, ".valid"}, 32'(valid_o), 32'd0);
        chk({tag, ".instr"}, instr_o,      NOP_I);
        chk({tag, ".bppc"},  bp_pc_o,      pc);
        chk({tag, ".plus"},  pc_plus_o,    pc);
    endtask

    task automatic fill_all32();
        for (int i = 0; i < 128; i++) mem[i] = (32'(i) << 12) | 32'h13;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        adv();
        adv();
        rst = 1'b0;
        samp();
        chk_bubble("rst_exit", 32'h0);
        adv();
    endtask

    function automatic logic [15:0] half_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[8:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    logic [31:0] mpc;
    logic [15:0] h0;
    logic [31:0] exp_ins;
    logic [31:0] exp_len;
    int          idle;

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; Stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        bp_taken_i = 1'b0; bp_target_i = '0; ICACHE_stall_i = 1'b0;
        fill_all32();

        // Outputs while reset is held
        adv();
        samp();
        chk_bubble("in_rst", 32'h0);
        chk("in_rst.pc",   pc_o, 32'h0);
        chk("in_rst.ren",  32'(ICACHE_ren_o), 32'd0);
        chk("in_rst.addr", 32'(ICACHE_addr_o), 32'd0);
        chk("in_rst.hit",  32'(BP_hit_o), 32'd0);
        adv();
        rst = 1'b0;
        samp();
        chk_bubble("reset_state", 32'h0);
        chk("reset_state.ren", 32'(ICACHE_ren_o), 32'd0);
        adv();

        // Aligned 32-bit stream
        for (int i = 0; i < 3; i++) begin
            samp();
            chk_issue("seq32", 32'(4 * i), mem[i], 32'(4 * i + 4));
            chk("seq32.addr", 32'(ICACHE_addr_o), 32'(i));
            adv();
        end

        // Two compressed in one word; the second needs no fetch
        mem[0] = {16'h4501, 16'h4581};
        do_reset();
        samp(); chk_issue("c2a", 32'h0, 32'h4581, 32'h2); chk("c2a.ren", 32'(ICACHE_ren_o), 32'd1); adv();
        samp(); chk_issue("c2b", 32'h2, 32'h4501, 32'h4); chk("c2b.ren", 32'(ICACHE_ren_o), 32'd0); adv();

        // 32-bit instruction straddling words 0 and 1
        mem[0] = {16'h0513, 16'h4581};
        mem[1] = {16'h4501, 16'h0000};
        mem[2] = 32'h0020_0013;
        do_reset();
        samp(); chk_issue("str0", 32'h0, 32'h4581, 32'h2); adv();
        samp(); chk_issue("str1", 32'h2, 32'h0000_0513, 32'h6);
        chk("str1.addr", 32'(ICACHE_addr_o), 32'd1); adv();
        samp(); chk_issue("str2", 32'h6, 32'h4501, 32'h8); chk("str2.ren", 32'(ICACHE_ren_o), 32'd0); adv();

        // Redirect to a misaligned 32-bit instruction: redirect cycle plus refill bubble
        mem[8'h40] = {16'h1537, 16'h4581};
        mem[8'h41] = {16'h4501, 16'h00AB};
        mem[8'h42] = 32'h1111_1093;
        redirect_i = 1'b1; redirect_pc_i = 32'h103;
        samp(); chk("redir.valid", 32'(valid_o), 32'd0); adv();
        redirect_i = 1'b0;
        samp(); chk_bubble("redir.b1", 32'h102); chk("redir.b1.addr", 32'(ICACHE_addr_o), 32'h40); adv();
        samp(); chk_bubble("redir.b2", 32'h102); chk("redir.b2.ren", 32'(ICACHE_ren_o), 32'd1); adv();
        samp(); chk_issue("redir.i", 32'h102, 32'h00AB_1537, 32'h106);
        chk("redir.i.addr", 32'(ICACHE_addr_o), 32'h41); adv();
        samp(); chk_issue("redir.c", 32'h106, 32'h4501, 32'h108); adv();

        // Cache stall together with pipeline stall, then redirect overrides both
        ICACHE_stall_i = 1'b1; Stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            samp(); chk_bubble("cstall", 32'h108); adv();
        end
        redirect_i = 1'b1; redirect_pc_i = 32'h200;
        samp(); chk("cstall.redir.valid", 32'(valid_o), 32'd0); adv();
        redirect_i = 1'b0; ICACHE_stall_i = 1'b0; Stall_i = 1'b0;
        samp(); chk_issue("after_redir", 32'h200, 32'h4581, 32'h202); adv();

        // Pipeline stall alone keeps the current instruction presented
        Stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            samp(); chk_issue("pstall", 32'h202, 32'h0000_0513, 32'h206); adv();
        end
        Stall_i = 1'b0;
        samp(); chk_issue("pstall.rel", 32'h202, 32'h0000_0513, 32'h206); adv();
        samp(); chk_issue("pstall.next", 32'h206, 32'h4501, 32'h208); adv();

        // Predicted-taken branch at pc 8
        fill_all32();
        do_reset();
        adv(); adv();
        bp_taken_i = 1'b1; bp_target_i = 32'h41;
        samp(); chk_issue("bp", 32'h8, mem[2], 32'hC); chk("bp.hit", 32'(BP_hit_o), 32'd1); adv();
        bp_taken_i = 1'b0;
        samp(); chk_issue("bp.tgt", 32'h40, mem[16], 32'h44); chk("bp.tgt.hit", 32'(BP_hit_o), 32'd0); adv();

        // Taken branch to the buffered halfword must not use the stale buffer
        mem[2] = {16'h4501, 16'h4581};
        do_reset();
        adv(); adv();
        bp_taken_i = 1'b1; bp_target_i = 32'hA;
        samp(); chk_issue("bpc", 32'h8, 32'h4581, 32'hA); chk("bpc.hit", 32'(BP_hit_o), 32'd1); adv();
        bp_taken_i = 1'b0;
        samp(); chk_bubble("bpc.b1", 32'hA); chk("bpc.b1.addr", 32'(ICACHE_addr_o), 32'd2); adv();
        samp(); chk_bubble("bpc.b2", 32'hA); adv();
        samp(); chk_issue("bpc.i", 32'hA, 32'h4501, 32'hC); adv();

        // PC wraps past the top of the address space
        mem[127] = 32'h4501_0013;
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
        samp(); adv();
        redirect_i = 1'b0;
        samp(); chk_bubble("wrap.b1", 32'hFFFF_FFFE); adv();
        samp(); chk_bubble("wrap.b2", 32'hFFFF_FFFE); adv();
        samp(); chk_issue("wrap.i", 32'hFFFF_FFFE, 32'h4501, 32'h0); adv();
        samp(); chk_issue("wrap.0", 32'h0, mem[0], 32'h4); adv();

        // Reset in the middle of a refill restarts from the reset PC
        redirect_i = 1'b1; redirect_pc_i = 32'h102;
        samp(); adv();
        redirect_i = 1'b0;
        samp(); adv();
        rst = 1'b1;
        samp(); chk_bubble("rst_refill", 32'h0); chk("rst_refill.ren", 32'(ICACHE_ren_o), 32'd0); adv();
        rst = 1'b0;
        samp(); chk_bubble("rst_refill.st", 32'h0); adv();
        samp(); chk_issue("rst_refill.i", 32'h0, mem[0], 32'h4); adv();

        // Randomized traffic against the memory-stream model
        for (int i = 0; i < 128; i++) begin
            logic [15:0] lo, hi;
            lo = 16'($urandom);
            hi = 16'($urandom);
            if ($urandom_range(0, 1) == 0) lo[0] = 1'b0; else lo[1:0] = 2'b11;
            if ($urandom_range(0, 1) == 0) hi[0] = 1'b0; else hi[1:0] = 2'b11;
            mem[i] = {hi, lo};
        end
        do_reset();
        mpc  = 32'h0;
        idle = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            redirect_i     = ($urandom_range(0, 99) < 4);
            redirect_pc_i  = 32'($urandom_range(0, 511));
            ICACHE_stall_i = ($urandom_range(0, 99) < 15);
            Stall_i        = ($urandom_range(0, 99) < 15);
            bp_taken_i     = ($urandom_range(0, 99) < 10);
            bp_target_i    = 32'($urandom_range(0, 511));
            samp();
            h0 = half_at(mpc);
            if (h0[1:0] != 2'b11) begin
                exp_ins = {16'h0000, h0};
                exp_len = 32'd2;
            end else begin
                exp_ins = {half_at(mpc + 32'd2), h0};
                exp_len = 32'd4;
            end
            chk("rnd.bppc", bp_pc_o, mpc);
            chk("rnd.pc", pc_o, mpc);
            if (redirect_i || ICACHE_stall_i) chk("rnd.blocked", 32'(valid_o), 32'd0);
            if (valid_o) begin
                chk("rnd.instr", instr_o, exp_ins);
                chk("rnd.plus", pc_plus_o, mpc + exp_len);
                chk("rnd.hit", 32'(BP_hit_o), 32'(bp_taken_i));
            end else begin
                chk("rnd.nop", instr_o, NOP_I);
                chk("rnd.nplus", pc_plus_o, mpc);
                chk("rnd.nhit", 32'(BP_hit_o), 32'd0);
            end
            if (valid_o || redirect_i) idle = 0;
            else if (!ICACHE_stall_i && !Stall_i) idle++;
            chk("rnd.progress", 32'(idle > 2), 32'd0);
            if (redirect_i) mpc = redirect_pc_i & 32'hFFFF_FFFE;
            else if (valid_o && !Stall_i) mpc = bp_taken_i ? (bp_target_i & 32'hFFFF_FFFE) : mpc + exp_len;
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
